// File: rtl/reg_writeback_arbiter.sv
// Register-file write-back arbiter: ALU results take priority over FIFO-buffered long-latency results; also tracks pending writes per register.
// Optional build macro WB_ARB_LL_BYPASS_EN lets an LL result go straight to the write port when the FIFO is empty and the ALU is idle.
module reg_writeback_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int SEL_WIDTH     = 4,
    parameter int NUM_REGS      = 16,
    parameter int LL_FIFO_DEPTH = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_issue_valid,
    input  logic [SEL_WIDTH-1:0]               in_issue_sel,
    input  logic                               in_alu_valid,
    input  logic [SEL_WIDTH-1:0]               in_alu_sel,
    input  logic [DATA_WIDTH-1:0]              in_alu_data,
    input  logic                               in_ll_valid,
    output logic                               out_ll_ready,
    input  logic [SEL_WIDTH-1:0]               in_ll_sel,
    input  logic [DATA_WIDTH-1:0]              in_ll_data,
    output logic                               out_write_en,
    output logic [SEL_WIDTH-1:0]               out_write_sel,
    output logic [DATA_WIDTH-1:0]              out_write_data,
    output logic [NUM_REGS-1:0]                out_busy,
    output logic [$clog2(LL_FIFO_DEPTH):0]     out_ll_count
);

    localparam int PTR_W = (LL_FIFO_DEPTH > 1) ? $clog2(LL_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(LL_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LL_FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] fifo_data_q [LL_FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [LL_FIFO_DEPTH];
    logic [SEL_WIDTH-1:0]  fifo_sel_q  [LL_FIFO_DEPTH];
    logic [SEL_WIDTH-1:0]  fifo_sel_d  [LL_FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  write_en_q, write_en_d;
    logic [SEL_WIDTH-1:0]  write_sel_q, write_sel_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic                  ll_xfer_s;
    logic                  win_valid_s;
    logic [SEL_WIDTH-1:0]  win_sel_s;
    logic [DATA_WIDTH-1:0] win_data_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  bypass_s;

    // Ready depends only on registered occupancy and reset, never on in_ll_valid.
    assign out_ll_ready = !rst && (count_q < DEPTH_CNT);
    assign ll_xfer_s    = in_ll_valid && out_ll_ready;

    // Pick this cycle's winner: ALU, else FIFO head, else (optionally) a bypassing LL transfer.
    always_comb begin
        win_valid_s = 1'b0;
        win_sel_s   = '0;
        win_data_s  = '0;
        pop_s       = 1'b0;
        bypass_s    = 1'b0;
        if (in_alu_valid) begin
            win_valid_s = 1'b1;
            win_sel_s   = in_alu_sel;
            win_data_s  = in_alu_data;
        end else if (count_q != '0) begin
            win_valid_s = 1'b1;
            win_sel_s   = fifo_sel_q[rd_ptr_q];
            win_data_s  = fifo_data_q[rd_ptr_q];
            pop_s       = 1'b1;
        end else begin
`ifdef WB_ARB_LL_BYPASS_EN
            if (ll_xfer_s) begin
                win_valid_s = 1'b1;
                win_sel_s   = in_ll_sel;
                win_data_s  = in_ll_data;
                bypass_s    = 1'b1;
            end else begin
                win_valid_s = 1'b0;
            end
`else
            win_valid_s = 1'b0;
`endif
        end
        push_s = ll_xfer_s && !bypass_s;
    end

    // FIFO next state; pointers wrap naturally because the depth is a power of two.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_sel_d  = fifo_sel_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (push_s) begin
            fifo_data_d[wr_ptr_q] = in_ll_data;
            fifo_sel_d[wr_ptr_q]  = in_ll_sel;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write port and scoreboard next state; a set on the same register overrides a clear.
    always_comb begin
        write_en_d   = win_valid_s && (win_sel_s != '0);
        write_sel_d  = write_sel_q;
        write_data_d = write_data_q;
        if (write_en_d) begin
            write_sel_d  = win_sel_s;
            write_data_d = win_data_s;
        end else begin
            write_sel_d  = write_sel_q;
            write_data_d = write_data_q;
        end
        busy_d = busy_q;
        if (write_en_q) begin
            busy_d[write_sel_q] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (in_issue_valid && (in_issue_sel != '0)) begin
            busy_d[in_issue_sel] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // Control state: reset discards FIFO contents, pending writes and the scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            write_en_q   <= 1'b0;
            write_sel_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            write_en_q   <= write_en_d;
            write_sel_q  <= write_sel_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
        end
    end

    // FIFO storage; entries are only meaningful between the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_sel_q  <= fifo_sel_d;
    end

    assign out_write_en   = write_en_q;
    assign out_write_sel  = write_sel_q;
    assign out_write_data = write_data_q;
    assign out_busy       = busy_q;
    assign out_ll_count   = count_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Randomized plus directed bench for reg_writeback_arbiter against a queue-based reference model.
module tb_reg_writeback_arbiter;

    localparam int DEPTH = 2;
`ifdef WB_ARB_LL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_issue_valid;
    logic [3:0]  in_issue_sel;
    logic        in_alu_valid;
    logic [3:0]  in_alu_sel;
    logic [31:0] in_alu_data;
    logic        in_ll_valid;
    logic        out_ll_ready;
    logic [3:0]  in_ll_sel;
    logic [31:0] in_ll_data;
    logic        out_write_en;
    logic [3:0]  out_write_sel;
    logic [31:0] out_write_data;
    logic [15:0] out_busy;
    logic [1:0]  out_ll_count;

    reg_writeback_arbiter #(
        .DATA_WIDTH(32), .SEL_WIDTH(4), .NUM_REGS(16), .LL_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_issue_valid(in_issue_valid), .in_issue_sel(in_issue_sel),
        .in_alu_valid(in_alu_valid), .in_alu_sel(in_alu_sel), .in_alu_data(in_alu_data),
        .in_ll_valid(in_ll_valid), .out_ll_ready(out_ll_ready),
        .in_ll_sel(in_ll_sel), .in_ll_data(in_ll_data),
        .out_write_en(out_write_en), .out_write_sel(out_write_sel),
        .out_write_data(out_write_data), .out_busy(out_busy), .out_ll_count(out_ll_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: pending LL results, pending-write bits, last write port contents.
    logic [35:0] mq [$];
    logic [15:0] m_busy;
    logic        m_en;
    logic [3:0]  m_sel;
    logic [31:0] m_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_busy = 16'h0000;
        m_en   = 1'b0;
        m_sel  = 4'h0;
        m_data = 32'h0;
    endtask

    // One cycle: drive at negedge, advance model, check everything at the next negedge.
    task automatic step(input logic r, input logic iv, input logic [3:0] isel,
                        input logic av, input logic [3:0] asel, input logic [31:0] adata,
                        input logic lv, input logic [3:0] lsel, input logic [31:0] ldata);
        logic        exp_rdy;
        logic        xfer;
        logic        wv;
        logic [3:0]  ws;
        logic [31:0] wd;
        logic [35:0] e;
        rst = r; in_issue_valid = iv; in_issue_sel = isel;
        in_alu_valid = av; in_alu_sel = asel; in_alu_data = adata;
        in_ll_valid = lv; in_ll_sel = lsel; in_ll_data = ldata;
        #1;
        exp_rdy = !r && (mq.size() < DEPTH);
        check_eq("ll_ready", {63'h0, out_ll_ready}, {63'h0, exp_rdy});
        xfer = lv && exp_rdy;
        if (r) begin
            model_reset();
        end else begin
            wv = 1'b0; ws = 4'h0; wd = 32'h0;
            if (av) begin
                wv = 1'b1; ws = asel; wd = adata;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                wv = 1'b1; ws = e[35:32]; wd = e[31:0];
            end else if (BYPASS && xfer) begin
                wv = 1'b1; ws = lsel; wd = ldata; xfer = 1'b0;
            end
            if (xfer) mq.push_back({lsel, ldata});
            if (m_en) m_busy[m_sel] = 1'b0;
            if (iv && isel != 4'h0) m_busy[isel] = 1'b1;
            m_en = wv && (ws != 4'h0);
            if (m_en) begin
                m_sel = ws; m_data = wd;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("write_en",   {63'h0, out_write_en},   {63'h0, m_en});
        check_eq("write_sel",  {60'h0, out_write_sel},  {60'h0, m_sel});
        check_eq("write_data", {32'h0, out_write_data}, {32'h0, m_data});
        check_eq("busy",       {48'h0, out_busy},       {48'h0, m_busy});
        check_eq("ll_count",   {62'h0, out_ll_count},   64'(mq.size()));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; in_issue_valid = 1'b0; in_issue_sel = 4'h0;
        in_alu_valid = 1'b0; in_alu_sel = 4'h0; in_alu_data = 32'h0;
        in_ll_valid = 1'b0; in_ll_sel = 4'h0; in_ll_data = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        check_eq("rst_ready", {63'h0, out_ll_ready}, 64'h0);
        check_eq("rst_busy",  {48'h0, out_busy},     64'h0);
        check_eq("rst_wen",   {63'h0, out_write_en}, 64'h0);
        idle();
        check_eq("ready_after_rst", {63'h0, out_ll_ready}, 64'h1);

        // Scoreboard set/clear
        step(1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        check_eq("sb_set5", {63'h0, out_busy[5]}, 64'h1);
        idle();
        check_eq("sb_hold5", {63'h0, out_busy[5]}, 64'h1);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0);
        check_eq("sb_wen",   {63'h0, out_write_en},   64'h1);
        check_eq("sb_wsel",  {60'h0, out_write_sel},  64'h5);
        check_eq("sb_wdata", {32'h0, out_write_data}, 64'hDEADBEEF);
        check_eq("sb_busy_at_write", {63'h0, out_busy[5]}, 64'h1);
        idle();
        check_eq("sb_clear5", {63'h0, out_busy[5]}, 64'h0);

        // LL latency
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h3, 32'h12345678);
        if (BYPASS) begin
            check_eq("ll_lat1_wen",  {63'h0, out_write_en},   64'h1);
            check_eq("ll_lat1_data", {32'h0, out_write_data}, 64'h12345678);
            idle();
        end else begin
            check_eq("ll_lat1_wen", {63'h0, out_write_en}, 64'h0);
            idle();
            check_eq("ll_lat2_wen",  {63'h0, out_write_en},   64'h1);
            check_eq("ll_lat2_data", {32'h0, out_write_data}, 64'h12345678);
        end
        idle();

        // ALU priority and FIFO fill
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'hA, 32'hA0, 1'b1, 4'h7, 32'h1);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'hB, 32'hB0, 1'b1, 4'h8, 32'h2);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'hC, 32'hC0, 1'b1, 4'h9, 32'h3);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'hD, 32'hD0, 1'b1, 4'h9, 32'h3);
        check_eq("fill_count", {62'h0, out_ll_count}, 64'h2);
        check_eq("fill_ready", {63'h0, out_ll_ready}, 64'h0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h9, 32'h3);
        check_eq("order_7", {60'h0, out_write_sel}, 64'h7);
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b1, 4'h9, 32'h3);
        check_eq("order_8", {60'h0, out_write_sel}, 64'h8);
        idle();
        check_eq("order_9",      {60'h0, out_write_sel},  64'h9);
        check_eq("order_9_data", {32'h0, out_write_data}, 64'h3);

        // Zero register
        step(1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0);
        check_eq("zero_wen",   {63'h0, out_write_en},   64'h0);
        check_eq("zero_busy0", {63'h0, out_busy[0]},    64'h0);
        check_eq("zero_hold",  {32'h0, out_write_data}, 64'h3);

        // Same-cycle set and clear
        step(1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'h4, 32'h44, 1'b0, 4'h0, 32'h0);
        step(1'b0, 1'b1, 4'h4, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        check_eq("setwins_busy4", {63'h0, out_busy[4]}, 64'h1);

        // Mid-operation reset
        step(1'b0, 1'b0, 4'h0, 1'b1, 4'h4, 32'h55, 1'b0, 4'h0, 32'h0);
        idle();
        step(1'b0, 1'b1, 4'h5, 1'b1, 4'h1, 32'h11, 1'b1, 4'h2, 32'hA);
        step(1'b0, 1'b1, 4'h8, 1'b1, 4'h1, 32'h12, 1'b1, 4'h3, 32'hB);
        check_eq("pre_rst_count", {62'h0, out_ll_count}, 64'h2);
        check_eq("pre_rst_busy",  {48'h0, out_busy},     64'h0120);
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
        check_eq("mid_rst_count", {62'h0, out_ll_count}, 64'h0);
        check_eq("mid_rst_busy",  {48'h0, out_busy},     64'h0);
        check_eq("mid_rst_wen",   {63'h0, out_write_en}, 64'h0);
        check_eq("mid_rst_ready", {63'h0, out_ll_ready}, 64'h0);
        idle();
        check_eq("post_rst_ready", {63'h0, out_ll_ready}, 64'h1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)), $urandom,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
